// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3, bus size, response code and state definitions for the data-memory bus interface
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_e;
  function automatic logic f3_legal(logic we, logic [2:0] f3);
    return we ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
              : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
  endfunction
  function automatic logic [1:0] f3_size(logic [2:0] f3);
    return f3[1:0] == 2'b10 ? SZ_WORD : f3[1:0] == 2'b01 ? SZ_HALF : SZ_BYTE;
  endfunction
  function automatic logic aligned(logic [1:0] sz, logic [1:0] a);
    return sz == SZ_WORD ? a == 2'b00 : sz == SZ_HALF ? !a[0] : 1'b1;
  endfunction
endpackage

// File: rtl/dmem_bus_if_load_extend.sv
// load_extend: sign/zero-extends raw bus data per load funct3 (funct3_i, raw_i -> ext_o)
module load_extend
  import dmem_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [2:0]   funct3_i,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] ext_o
);
  always_comb
    ext_o = funct3_i == F3_B  ? {{(W-8){raw_i[7]}}, raw_i[7:0]} :
            funct3_i == F3_BU ? {{(W-8){1'b0}}, raw_i[7:0]} :
            funct3_i == F3_H  ? {{(W-16){raw_i[15]}}, raw_i[15:0]} :
            funct3_i == F3_HU ? {{(W-16){1'b0}}, raw_i[15:0]} :
            raw_i;
endmodule

// File: rtl/dmem_bus_if.sv
// dmem_bus_if: one-at-a-time load/store bridge (req_*/resp_* from the memory stage, DAD/DDT/MREQ/WRITE/SIZE/ACKD_n to the bus) with alignment, funct3 and timeout checks
module dmem_bus_if
  import dmem_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int TIMEOUT   = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [BIT_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [BIT_WIDTH-1:0] resp_rdata,
  output logic [1:0]           resp_err,
  output logic [BIT_WIDTH-1:0] DAD,
  inout  wire  [BIT_WIDTH-1:0] DDT,
  output logic                 MREQ,
  output logic                 WRITE,
  output logic [1:0]           SIZE,
  input  logic                 ACKD_n
);
  localparam int CL = $clog2(TIMEOUT);
  localparam int CW = CL < 8 ? 8 : CL > 32 ? 32 : CL;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [BIT_WIDTH-1:0] dad_q, wdata_q, rdata_q;
  logic [2:0]           f3_q;
  logic [1:0]           size_q, err_q;
  logic                 we_q, mreq_q, oe_q, ready_q, rvalid_q;
  logic [1:0]           req_size, req_err;
  logic [BIT_WIDTH-1:0] wdata_sized, ext;
  always_comb begin
    req_size    = f3_size(req_funct3);
    req_err     = !f3_legal(req_we, req_funct3) ? ERR_ILLEGAL :
                  !aligned(req_size, req_addr[1:0]) ? ERR_MISALIGN : ERR_OK;
    wdata_sized = req_size == SZ_BYTE ? {{(BIT_WIDTH-8){1'b0}}, req_wdata[7:0]} :
                  req_size == SZ_HALF ? {{(BIT_WIDTH-16){1'b0}}, req_wdata[15:0]} : req_wdata;
  end
  load_extend #(.W(BIT_WIDTH)) u_ext (.funct3_i(f3_q), .raw_i(DDT), .ext_o(ext));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      dad_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      f3_q     <= '0;
      size_q   <= SZ_WORD;
      err_q    <= ERR_OK;
      we_q     <= 1'b0;
      mreq_q   <= 1'b0;
      oe_q     <= 1'b0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (req_valid) begin
          ready_q <= 1'b0;
          err_q   <= req_err;
          rdata_q <= '0;
          cnt_q   <= '0;
          if (req_err == ERR_OK) begin
            state_q <= ST_BUS;
            mreq_q  <= 1'b1;
            oe_q    <= req_we;
            we_q    <= req_we;
            size_q  <= req_size;
            dad_q   <= req_addr;
            wdata_q <= wdata_sized;
            f3_q    <= req_funct3;
          end else begin
            state_q  <= ST_RESP;
            rvalid_q <= 1'b1;
          end
        end
        ST_BUS: if (!ACKD_n || cnt_q == TO_LAST) begin
          state_q  <= ST_RESP;
          mreq_q   <= 1'b0;
          oe_q     <= 1'b0;
          rvalid_q <= 1'b1;
          err_q    <= !ACKD_n ? ERR_OK : ERR_TIMEOUT;
          rdata_q  <= (!ACKD_n && !we_q) ? ext : '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
        default: begin
          state_q  <= ST_IDLE;
          rvalid_q <= 1'b0;
          ready_q  <= 1'b1;
        end
      endcase
    end
  end
  assign DDT        = oe_q ? wdata_q : 'z;
  assign DAD        = dad_q;
  assign MREQ       = mreq_q;
  assign WRITE      = we_q;
  assign SIZE       = size_q;
  assign req_ready  = ready_q;
  assign resp_valid = rvalid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
endmodule

// File: tb/tb_dmem_bus_if.sv
// tb_dmem_bus_if: directed and random load/store accesses against a behavioural bus/memory model
module tb_dmem_bus_if;
  localparam int TO = 16;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_we = 1'b0, ACKD_n = 1'b1;
  logic [2:0] req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, mem_word = '0;
  wire req_ready, resp_valid, MREQ, WRITE;
  wire [31:0] resp_rdata, DAD, DDT;
  wire [1:0] resp_err, SIZE;
  int total = 0, bad = 0;
  assign DDT = (MREQ && WRITE) ? 'z : (MREQ ? mem_word : 32'h0);
  dmem_bus_if #(.BIT_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .DAD(DAD), .DDT(DDT), .MREQ(MREQ),
    .WRITE(WRITE), .SIZE(SIZE), .ACKD_n(ACKD_n));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction
  function automatic logic [1:0] m_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int n;
    logic legal;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 2'd2;
    n = nbytes(f3);
    return (a % n) != 0 ? 2'd1 : 2'd0;
  endfunction
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] rd);
    int v;
    if (nbytes(f3) == 4) return rd;
    v = (nbytes(f3) == 1) ? int'(rd % 256) : int'(rd % 65536);
    if (f3 < 4 && nbytes(f3) == 1 && v >= 128) v -= 256;
    if (f3 < 4 && nbytes(f3) == 2 && v >= 32768) v -= 65536;
    return 32'(v);
  endfunction
  task automatic access(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rd, input int ack_lat);
    int cyc, mcyc, n, exp_mcyc;
    logic [1:0] e, exp_err, exp_size;
    logic [31:0] mask, exp_rd;
    logic timed;
    e = m_err(we, f3, addr);
    n = nbytes(f3);
    exp_size = n == 4 ? 2'd0 : n == 2 ? 2'd1 : 2'd2;
    mask = n == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
    timed = e == 0 && (ack_lat == 0 || ack_lat > TO);
    exp_mcyc = e != 0 ? 0 : timed ? TO : ack_lat;
    exp_err = e != 0 ? e : timed ? 2'd3 : 2'd0;
    exp_rd = (exp_err == 0 && !we) ? m_load(f3, rd) : 32'h0;
    mem_word = rd;
    @(negedge clk);
    chk({tag, " ready_before"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; mcyc = 0;
    while (!resp_valid && cyc < 100) begin
      if (MREQ) begin
        mcyc++;
        chk({tag, " DAD"}, DAD, addr);
        chk({tag, " SIZE"}, 32'(SIZE), 32'(exp_size));
        chk({tag, " WRITE"}, 32'(WRITE), 32'(we));
        if (we) chk({tag, " DDT_store"}, DDT & mask, wdata & mask);
      end
      ACKD_n = !(MREQ && mcyc == ack_lat);
      @(negedge clk);
      cyc++;
    end
    ACKD_n = 1'b1;
    chk({tag, " latency"}, 32'(cyc), 32'(exp_mcyc + 1));
    chk({tag, " mreq_cycles"}, 32'(mcyc), 32'(exp_mcyc));
    chk({tag, " err"}, 32'(resp_err), 32'(exp_err));
    chk({tag, " rdata"}, resp_rdata, exp_rd);
    chk({tag, " ready_in_resp"}, 32'(req_ready), 32'd0);
    chk({tag, " mreq_at_resp"}, 32'(MREQ), 32'd0);
    @(negedge clk);
    chk({tag, " valid_pulse"}, 32'(resp_valid), 32'd0);
    chk({tag, " ready_after"}, 32'(req_ready), 32'd1);
    chk({tag, " ddt_released"}, DDT, 32'h0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst MREQ", 32'(MREQ), 32'd0);
    chk("rst WRITE", 32'(WRITE), 32'd0);
    chk("rst SIZE", 32'(SIZE), 32'd0);
    chk("rst DAD", DAD, 32'h0);
    chk("rst DDT", DDT, 32'h0);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'h0);
    chk("rst resp_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    access("lw", 1'b0, 3'b010, 32'h0800_0000, 32'h0, 32'h1234_5678, 1);
    access("lb", 1'b0, 3'b000, 32'h0800_0003, 32'h0, 32'hABCD_EF80, 1);
    access("lbu", 1'b0, 3'b100, 32'h0800_0003, 32'h0, 32'hABCD_EF80, 2);
    access("lh", 1'b0, 3'b001, 32'h0800_0002, 32'h0, 32'h1111_9234, 3);
    access("lhu", 1'b0, 3'b101, 32'h0800_0002, 32'h0, 32'h1111_9234, 1);
    access("sb", 1'b1, 3'b000, 32'hF000_0000, 32'h0000_0041, 32'h0, 2);
    access("sw", 1'b1, 3'b010, 32'hF000_0004, 32'hCAFE_BABE, 32'h0, 1);
    access("sh_mis", 1'b1, 3'b001, 32'h0800_0001, 32'h1234, 32'h0, 1);
    access("lw_mis", 1'b0, 3'b010, 32'h0800_0002, 32'h0, 32'h0, 1);
    access("ld_ill", 1'b0, 3'b011, 32'h0800_0001, 32'h0, 32'h0, 1);
    access("st_ill", 1'b1, 3'b100, 32'h0800_0000, 32'h0, 32'h0, 1);
    access("ack_last", 1'b0, 3'b010, 32'h0800_0010, 32'h0, 32'h5555_AAAA, TO);
    access("timeout", 1'b0, 3'b010, 32'h0800_0020, 32'h0, 32'h7777_7777, 0);
    ACKD_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("late_ack valid", 32'(resp_valid), 32'd0);
      chk("late_ack MREQ", 32'(MREQ), 32'd0);
    end
    ACKD_n = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0800_0040; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstbus MREQ_up", 32'(MREQ), 32'd1);
    @(negedge clk);
    chk("rstbus DDT_driven", DDT, 32'hDEAD_BEEF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstbus MREQ", 32'(MREQ), 32'd0);
    chk("rstbus DDT", DDT, 32'h0);
    chk("rstbus ready", 32'(req_ready), 32'd1);
    chk("rstbus valid", 32'(resp_valid), 32'd0);
    ACKD_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rstbus no_resp", 32'(resp_valid), 32'd0);
    end
    ACKD_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic we;
      logic [2:0] f3;
      logic [31:0] a;
      int r, lat;
      we = 1'($urandom % 2);
      f3 = 3'($urandom % 8);
      a = {$urandom} & 32'hFFFF_FFF0;
      a = a | 32'($urandom % 4);
      r = int'($urandom % 10);
      lat = r == 0 ? 0 : r == 1 ? TO : r == 2 ? TO + 1 : 1 + int'($urandom % 4);
      access($sformatf("rnd%0d", i), we, f3, a, $urandom, $urandom, lat);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
